mips_stim_sequencer: RTL and testbench

//  Synthesizable, parametrised stimulus engine for the MIPS top level, usable in simulation and on the

---
 rtl/mips_stim_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mips_stim_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_stim_sequencer.sv
// Stimulus engine for the MIPS top level: DUT reset sequence, optional step pulses and a
// queued pattern of active-low button levels replayed during a fixed-length RUN window.
module mips_stim_sequencer #(
    parameter int NUM_CH      = 6,
    parameter int DEPTH       = 8,
    parameter int PRE_RST_CYC = 5,
    parameter int RST_CYC     = 3,
    parameter int SETTLE_CYC  = 10,
    parameter int RUN_CYC     = 250000,
    parameter int STEP_DIV    = 0,
    parameter int CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              pat_valid_i,
    output logic              pat_ready_o,
    input  logic [NUM_CH-1:0] pat_buttons_i,
    input  logic [15:0]       pat_hold_i,
    output logic              dut_rst_o,
    output logic              step_o,
    output logic [NUM_CH-1:0] buttons_o,
    output logic              running_o,
    output logic              done_o,
    output logic              underrun_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0]      PRE_LAST = 32'(PRE_RST_CYC - 1);
    localparam logic [31:0]      RST_LAST = 32'(RST_CYC - 1);
    localparam logic [31:0]      SET_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0]      SD_LAST  = (STEP_DIV > 0) ? 32'(STEP_DIV - 1) : 32'd0;
    localparam logic [CNT_W-1:0] RUN_END  = CNT_W'(RUN_CYC);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_RST, S_SETTLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [31:0]         phase_q, phase_d;
    logic [31:0]         sdiv_q, sdiv_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         hold_q, hold_d;
    logic [NUM_CH-1:0]   btn_q, btn_d;
    logic                und_q, und_d;
    logic                popped_q, popped_d;
    logic                dut_rst_q, running_q, done_q, step_q, step_d;
    logic                clr_run, abort_act, push, pop, empty, full;
    logic [AW:0]         wptr_q, rptr_q;
    logic [NUM_CH-1:0]   mem_b [DEPTH];
    logic [15:0]         mem_h [DEPTH];

    assign abort_act = abort_i && (state_q != S_IDLE);
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push      = pat_valid_i && !full && !abort_act;
    // Pops only while staying in RUN so the exit edge leaves buttons released.
    assign pop       = (state_q == S_RUN) && (state_d == S_RUN) && (hold_q == 16'd0) && !empty;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        clr_run = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_PRE;
                phase_d = '0;
                clr_run = 1'b1;
            end
            S_PRE: if (phase_q == PRE_LAST) begin
                state_d = S_RST;
                phase_d = '0;
            end else phase_d = phase_q + 32'd1;
            S_RST: if (phase_q == RST_LAST) begin
                state_d = S_SETTLE;
                phase_d = '0;
            end else phase_d = phase_q + 32'd1;
            S_SETTLE: if (phase_q == SET_LAST) begin
                state_d = S_RUN;
                phase_d = '0;
            end else phase_d = phase_q + 32'd1;
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == RUN_END) state_d = S_DONE;
            end
            S_DONE: if (start_i) begin
                state_d = S_PRE;
                phase_d = '0;
                cnt_d   = '0;
                clr_run = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_act) begin
            state_d = S_IDLE;
            phase_d = '0;
            cnt_d   = '0;
        end
    end

    // sdiv tracks cycle_cnt modulo STEP_DIV without a divider.
    always_comb begin
        sdiv_d = '0;
        if (state_d == S_RUN && state_q == S_RUN)
            sdiv_d = (sdiv_q == SD_LAST) ? 32'd0 : sdiv_q + 32'd1;
        step_d = (STEP_DIV > 0) && (state_d == S_RUN) && (sdiv_d == SD_LAST);
    end

    always_comb begin
        hold_d   = hold_q;
        btn_d    = btn_q;
        und_d    = und_q;
        popped_d = popped_q;
        if (state_q == S_RUN && state_d == S_RUN) begin
            if (hold_q != 16'd0) begin
                hold_d = hold_q - 16'd1;
            end else if (pop) begin
                btn_d    = mem_b[rptr_q[AW-1:0]];
                hold_d   = (mem_h[rptr_q[AW-1:0]] == 16'd0) ? 16'd0 : mem_h[rptr_q[AW-1:0]] - 16'd1;
                popped_d = 1'b1;
            end else begin
                btn_d = '1;
                if (popped_q) und_d = 1'b1;
            end
        end else begin
            hold_d = '0;
            btn_d  = '1;
        end
        if (clr_run || abort_act) begin
            und_d    = 1'b0;
            popped_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            sdiv_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            btn_q     <= '1;
            und_q     <= 1'b0;
            popped_q  <= 1'b0;
            dut_rst_q <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            step_q    <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            sdiv_q    <= sdiv_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            btn_q     <= btn_d;
            und_q     <= und_d;
            popped_q  <= popped_d;
            dut_rst_q <= (state_d != S_RST);
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
            step_q    <= step_d;
            if (abort_act) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + (AW+1)'(1);
                if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_b[wptr_q[AW-1:0]] <= pat_buttons_i;
            mem_h[wptr_q[AW-1:0]] <= pat_hold_i;
        end
    end

    assign pat_ready_o = !full;
    assign dut_rst_o   = dut_rst_q;
    assign step_o      = step_q;
    assign buttons_o   = btn_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign underrun_o  = und_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_mips_stim_sequencer.sv
// Bench for mips_stim_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a phase-arithmetic / queue reference model.
module tb_mips_stim_sequencer;
    localparam int NCH = 6, DEPTH = 8, PRE = 5, RSTC = 3, SET = 10, RUNC = 40, SD = 4;
    localparam int T_RUN = PRE + RSTC + SET;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 0, abort = 0, pat_valid = 0;
    logic [NCH-1:0] pat_buttons = '0;
    logic [15:0] pat_hold = '0;
    logic pat_ready, dut_rst, step, running, done, underrun;
    logic [NCH-1:0] buttons;
    logic [31:0] cycle_cnt;

    mips_stim_sequencer #(.NUM_CH(NCH), .DEPTH(DEPTH), .PRE_RST_CYC(PRE), .RST_CYC(RSTC),
        .SETTLE_CYC(SET), .RUN_CYC(RUNC), .STEP_DIV(SD), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .abort_i(abort),
        .pat_valid_i(pat_valid), .pat_ready_o(pat_ready), .pat_buttons_i(pat_buttons),
        .pat_hold_i(pat_hold), .dut_rst_o(dut_rst), .step_o(step), .buttons_o(buttons),
        .running_o(running), .done_o(done), .underrun_o(underrun), .cycle_cnt_o(cycle_cnt));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: "since" counts edges after the accepted start edge; phase follows by arithmetic.
    typedef struct { logic [NCH-1:0] b; int h; } ent_t;
    ent_t q[$];
    bit m_idle = 1, m_und = 0, m_pop = 0, last_acc = 0;
    int since = 0, m_rem = 0;
    logic [NCH-1:0] m_btn = '1;

    function automatic int ph();
        if (m_idle) return 0;
        if (since < PRE) return 1;
        if (since < PRE + RSTC) return 2;
        if (since < T_RUN) return 3;
        if (since < T_RUN + RUNC) return 4;
        return 5;
    endfunction

    function automatic void model_reset();
        m_idle = 1; since = 0; q.delete(); m_rem = 0; m_btn = '1; m_und = 0; m_pop = 0;
    endfunction

    task automatic model_step();
        int p0, p1;
        bit acc, go;
        ent_t e;
        p0 = ph();
        acc = pat_valid && (q.size() < DEPTH);
        if (abort && p0 != 0) begin
            model_reset();
            return;
        end
        go = start && (p0 == 0 || p0 == 5);
        if (go) begin
            m_idle = 0; since = 0;
        end else if (p0 != 0 && since < T_RUN + RUNC) since++;
        p1 = ph();
        if (p0 == 4 && p1 == 4) begin
            if (m_rem > 0) m_rem--;
            else if (q.size() > 0) begin
                e = q.pop_front();
                m_btn = e.b; m_rem = (e.h == 0) ? 0 : e.h - 1; m_pop = 1;
            end else begin
                m_btn = '1;
                if (m_pop) m_und = 1;
            end
        end else begin
            m_btn = '1; m_rem = 0;
        end
        if (go) begin m_und = 0; m_pop = 0; end
        if (acc) begin
            e.b = pat_buttons; e.h = int'(pat_hold);
            q.push_back(e);
        end
    endtask

    task automatic check_all();
        int p, cc;
        p = ph();
        cc = (p == 4) ? since - T_RUN : (p == 5) ? RUNC : 0;
        chk("dut_rst", dut_rst, p != 2);
        chk("running", running, p == 4);
        chk("done", done, p == 5);
        chk("cycle_cnt", cycle_cnt, cc);
        chk("step", step, (p == 4) && ((cc + 1) % SD == 0));
        chk("buttons", buttons, m_btn);
        chk("underrun", underrun, m_und);
        chk("pat_ready", pat_ready, q.size() < DEPTH);
    endtask

    task automatic cyc(input bit s_, input bit a_, input bit v_, input logic [NCH-1:0] b_,
                       input logic [15:0] h_);
        start = s_; abort = a_; pat_valid = v_; pat_buttons = b_; pat_hold = h_;
        last_acc = v_ && pat_ready;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        start = 0; abort = 0; pat_valid = 0;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("arst_dut_rst", dut_rst, 1'b1);
        chk("arst_running", running, 1'b0);
        chk("arst_buttons", buttons, 6'h3F);
        chk("arst_cycle_cnt", cycle_cnt, 0);
        chk("arst_ready", pat_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rise, nstep, nacc, at;
        repeat (2) @(negedge clk);
        chk("rst_dut_rst", dut_rst, 1'b1);
        chk("rst_buttons", buttons, 6'h3F);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", pat_ready, 1'b1);
        rst_n = 1'b1;
        cyc(0, 0, 0, '0, 0);

        // Preloaded pattern, reset timing and step count over a full run.
        cyc(0, 0, 1, 6'b111110, 4);
        cyc(0, 0, 1, 6'b011111, 0);
        cyc(1, 0, 0, '0, 0);
        rise = -1; nstep = 0;
        for (int i = 1; i <= T_RUN + RUNC + 2; i++) begin
            cyc(0, 0, 0, '0, 0);
            if (running && rise < 0) rise = i;
            if (step) nstep++;
            if (i == 7)  chk("t1_rst_low", dut_rst, 1'b0);
            if (i == 22) chk("t2_btn_a", buttons, 6'b111110);
            if (i == 23) begin chk("t2_btn_b", buttons, 6'b011111); chk("t2_und0", underrun, 0); end
            if (i == 24) begin chk("t2_btn_idle", buttons, 6'h3F); chk("t2_und1", underrun, 1); end
        end
        chk("t1_run_rise", rise, 18);
        chk("t4_step_cnt", nstep, RUNC / SD);
        chk("t4_done", done, 1'b1);
        chk("t4_cnt", cycle_cnt, RUNC);
        chk("t4_step_done", step, 1'b0);

        // Fill the FIFO in DONE, ninth entry must wait for the first pop.
        nacc = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 1, 6'($urandom), 2);
            if (last_acc) nacc++;
        end
        chk("t3_acc8", nacc, 8);
        chk("t3_full", pat_ready, 1'b0);
        cyc(1, 0, 1, 6'h15, 1);
        at = -1;
        for (int i = 1; i <= 40 && at < 0; i++) begin
            cyc(0, 0, 1, 6'h15, 1);
            if (last_acc) at = i;
        end
        chk("t3_ninth_edge", at, 20);
        for (int i = 0; i < 100 && !done; i++) cyc(0, 0, 0, '0, 0);
        chk("t3_done", done, 1'b1);

        // start+abort together from DONE, then start alone.
        cyc(1, 1, 0, '0, 0);
        chk("t6_idle_run", running, 1'b0);
        chk("t6_idle_done", done, 1'b0);
        cyc(1, 0, 0, '0, 0);
        chk("t6_pre_cnt", cycle_cnt, 0);
        chk("t6_pre_done", done, 1'b0);

        // Abort during RST with queued entries, then async reset mid-RUN.
        cyc(1, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 6'($urandom), 3);
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, '0, 0);
        chk("t5_in_rst", dut_rst, 1'b0);
        cyc(0, 1, 0, '0, 0);
        chk("t5_ready", pat_ready, 1'b1);
        chk("t5_dut_rst", dut_rst, 1'b1);
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 25; i++) cyc(0, 0, 0, '0, 0);
        chk("t5_btn_flushed", buttons, 6'h3F);
        async_reset();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(399) == 0) async_reset();
            else cyc($urandom_range(7) == 0, $urandom_range(59) == 0, $urandom_range(9) < 4,
                     6'($urandom), 16'($urandom_range(6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
